alu_ctrl_pipe: RTL and testbench

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

---
 rtl/alu_ctrl_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe
// Decodes a RISC-V style (alu_op, funct3, funct7, opcode) tuple into an ALU
// operation code plus an "illegal encoding" flag, and delivers the result
// through a 2-entry (output register + skid register) valid/ready pipeline.
// Two saturating statistics counters track delivered and illegal results.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is registered and equals "skid register empty". Once
// out_valid is 1 it stays 1, and alu_ctrl/illegal/out_tag stay stable, until
// out_ready is 1 (or flush/reset empties the block).
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   flush                 empty both entries next cycle, drop this cycle's input
//   in_valid / in_ready   input decode request handshake
//   alu_op, funct3, funct7, op, in_tag   decode request fields
//   out_valid / out_ready result handshake
//   alu_ctrl, illegal, out_tag           decoded result
//   cnt_total, cnt_illegal               saturating delivered / illegal counts
module alu_ctrl_pipe #(
  parameter int CTRL_W = 4,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  // Only op[5] (R-type vs I-type arithmetic) matters to the decode.
  logic unused_op;
  assign unused_op = ^{op[6], op[4:0]};

  // Returns {illegal, ctrl}.
  function automatic logic [4:0] decode(input logic [1:0] aop,
                                        input logic [2:0] f3,
                                        input logic [6:0] f7,
                                        input logic       op5);
    logic [3:0] c;
    logic       ill;
    logic       f7_zero;
    logic       f7_alt;
    c       = OP_ADD;
    ill     = 1'b0;
    f7_zero = (f7 == 7'b0000000);
    f7_alt  = (f7 == 7'b0100000);
    case (aop)
      2'b00: c = OP_ADD;
      2'b01: begin
        case (f3[2:1])
          2'b10:   c = OP_SLT;
          2'b11:   c = OP_SLTU;
          default: c = OP_SUB;
        endcase
      end
      default: begin
        // R-type and I-type share one funct3 table; only 000 differs.
        case (f3)
          3'b000:  c = (aop == 2'b10 && op5 && f7[5]) ? OP_SUB : OP_ADD;
          3'b001:  c = OP_SLL;
          3'b010:  c = OP_SLT;
          3'b011:  c = OP_SLTU;
          3'b100:  c = OP_XOR;
          3'b101:  c = f7[5] ? OP_SRA : OP_SRL;
          3'b110:  c = OP_OR;
          default: c = OP_AND;
        endcase
        if (aop == 2'b10) begin
          ill = !(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
        end else begin
          ill = (f3 == 3'b001 && !f7_zero) ||
                (f3 == 3'b101 && !(f7_zero || f7_alt));
        end
        if (ill) c = OP_ADD;
      end
    endcase
    return {ill, c};
  endfunction

  logic [3:0] dec_ctrl;
  logic       dec_ill;

  always_comb begin
    {dec_ill, dec_ctrl} = decode(alu_op, funct3, funct7, op[5]);
  end

  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_ctrl_q, out_ctrl_d;
  logic              out_ill_q, out_ill_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              skid_valid_q, skid_valid_d;
  logic [3:0]        skid_ctrl_q, skid_ctrl_d;
  logic              skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0]  cnt_illegal_q, cnt_illegal_d;
  logic              accept;
  logic              fire;

  always_comb begin
    accept        = in_valid & in_ready_q;
    fire          = out_valid_q & out_ready;
    out_valid_d   = out_valid_q;
    out_ctrl_d    = out_ctrl_q;
    out_ill_d     = out_ill_q;
    out_tag_d     = out_tag_q;
    skid_valid_d  = skid_valid_q;
    skid_ctrl_d   = skid_ctrl_q;
    skid_ill_d    = skid_ill_q;
    skid_tag_d    = skid_tag_q;
    cnt_total_d   = cnt_total_q;
    cnt_illegal_d = cnt_illegal_q;

    // Counters see every fire, including one that coincides with flush.
    if (fire && cnt_total_q != {CNT_W{1'b1}}) begin
      cnt_total_d = cnt_total_q + 1'b1;
    end
    if (fire && out_ill_q && cnt_illegal_q != {CNT_W{1'b1}}) begin
      cnt_illegal_d = cnt_illegal_q + 1'b1;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire) begin
      // accept cannot coincide with a full skid: in_ready is 0 then.
      if (skid_valid_q) begin
        out_ctrl_d   = skid_ctrl_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_ctrl_d = dec_ctrl;
        out_ill_d  = dec_ill;
        out_tag_d  = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = dec_ctrl;
        out_ill_d   = dec_ill;
        out_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = dec_ctrl;
        skid_ill_d   = dec_ill;
        skid_tag_d   = in_tag;
      end
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_ctrl_q    <= '0;
      out_ill_q     <= 1'b0;
      out_tag_q     <= '0;
      skid_valid_q  <= 1'b0;
      skid_ctrl_q   <= '0;
      skid_ill_q    <= 1'b0;
      skid_tag_q    <= '0;
      in_ready_q    <= 1'b0;
      cnt_total_q   <= '0;
      cnt_illegal_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_ctrl_q    <= out_ctrl_d;
      out_ill_q     <= out_ill_d;
      out_tag_q     <= out_tag_d;
      skid_valid_q  <= skid_valid_d;
      skid_ctrl_q   <= skid_ctrl_d;
      skid_ill_q    <= skid_ill_d;
      skid_tag_q    <= skid_tag_d;
      in_ready_q    <= in_ready_d;
      cnt_total_q   <= cnt_total_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  always_comb begin
    alu_ctrl      = '0;
    alu_ctrl[3:0] = out_ctrl_q;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign illegal     = out_ill_q;
  assign out_tag     = out_tag_q;
  assign cnt_total   = cnt_total_q;
  assign cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed scenarios plus randomized traffic, all
// checked against a queue-level reference model with saturating counters.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_alu_ctrl_pipe;
  localparam int TAG_W = 5;
  localparam int QW    = TAG_W + 5;

  logic             clk, rst, flush, in_valid, out_ready;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic [6:0]       funct7, op;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready, out_valid, illegal;
  logic [3:0]       alu_ctrl;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      cnt_total, cnt_illegal;

  logic             s_in_ready, s_out_valid, s_illegal;
  logic [3:0]       s_alu_ctrl;
  logic [TAG_W-1:0] s_out_tag;
  logic [1:0]       s_cnt_total, s_cnt_illegal;

  alu_ctrl_pipe #(.CTRL_W(4), .TAG_W(TAG_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .out_tag(out_tag), .cnt_total(cnt_total),
    .cnt_illegal(cnt_illegal)
  );

  alu_ctrl_pipe #(.CTRL_W(4), .TAG_W(TAG_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op(op), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready), .alu_ctrl(s_alu_ctrl),
    .illegal(s_illegal), .out_tag(s_out_tag), .cnt_total(s_cnt_total),
    .cnt_illegal(s_cnt_illegal)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state: expected queue holds {tag, illegal, ctrl}
  logic [QW-1:0] exp_q[$];
  bit  m_in_ready;
  bit  m_in_reset;
  int  m_cnt, m_ill, m_scnt, m_sill;
  int  n_total, n_bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Spec-level decode: returns {illegal, ctrl}.
  function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [6:0] o);
    logic [3:0] rtab [8];
    logic [3:0] c;
    bit legal;
    rtab = '{4'h0, 4'h3, 4'h7, 4'h9, 4'h2, 4'h8, 4'h6, 4'h5};
    if (a == 2'd0) return {1'b0, 4'h0};
    if (a == 2'd1) begin
      if (f3 >= 3'd6) return {1'b0, 4'h9};
      if (f3 >= 3'd4) return {1'b0, 4'h7};
      return {1'b0, 4'h1};
    end
    if (a == 2'd2) legal = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
    else legal = !((f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32));
    if (!legal) return {1'b1, 4'h0};
    c = rtab[f3];
    if (a == 2'd2 && f3 == 3'd0 && o[5] && f7 == 7'd32) c = 4'h1;
    if (f3 == 3'd5 && f7 == 7'd32) c = 4'h4;
    return {1'b0, c};
  endfunction

  // driver tasks
  task automatic drive(input bit v, input logic [1:0] a, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [6:0] o, input logic [TAG_W-1:0] t);
    in_valid = v; alu_op = a; funct3 = f3; funct7 = f7; op = o; in_tag = t;
  endtask

  task automatic check_all();
    logic [QW-1:0] f;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, m_in_ready);
    chk("sat_out_valid", s_out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      chk("alu_ctrl", alu_ctrl, f[3:0]);
      chk("illegal", illegal, f[4]);
      chk("out_tag", out_tag, f[QW-1:5]);
    end
    if (m_in_reset) begin
      chk("rst_alu_ctrl", alu_ctrl, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_out_tag", out_tag, 0);
    end
    chk("cnt_total", cnt_total, m_cnt);
    chk("cnt_illegal", cnt_illegal, m_ill);
    chk("sat_cnt_total", s_cnt_total, m_scnt);
    chk("sat_cnt_illegal", s_cnt_illegal, m_sill);
  endtask

  // Advance the model for the upcoming edge, clock it, then check on negedge.
  task automatic step();
    logic [QW-1:0] f;
    bit acc, fire;
    acc  = rst && in_valid && m_in_ready;
    fire = rst && exp_q.size() > 0 && out_ready;
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0; m_ill = 0; m_scnt = 0; m_sill = 0;
      m_in_ready = 0;
    end else begin
      if (fire) begin
        f = exp_q.pop_front();
        if (m_cnt < 65535) m_cnt++;
        if (m_scnt < 3) m_scnt++;
        if (f[4]) begin
          if (m_ill < 65535) m_ill++;
          if (m_sill < 3) m_sill++;
        end
      end
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back({in_tag, ref_decode(alu_op, funct3, funct7, op)});
      m_in_ready = exp_q.size() < 2;
    end
    m_in_reset = !rst;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_seq();
    rst = 1'b0; flush = 1'b0;
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    m_cnt = 0; m_ill = 0; m_scnt = 0; m_sill = 0;
    m_in_ready = 0; m_in_reset = 0;
    out_ready = 1'b0;
    reset_seq();
    chk("reset_in_ready", in_ready, 1);

    // R-type SUB
    out_ready = 1'b1;
    drive(1, 2'b10, 3'b000, 7'b0100000, 7'b0110011, 5'd7);
    step();
    chk("sub_valid", out_valid, 1);
    chk("sub_ctrl", alu_ctrl, 4'b0001);
    chk("sub_tag", out_tag, 7);
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();

    // I-type SRA then illegal shift, back to back
    reset_seq();
    out_ready = 1'b1;
    drive(1, 2'b11, 3'b101, 7'b0100000, 7'b0010011, 5'd1);
    step();
    chk("sra_ctrl", alu_ctrl, 4'b0100);
    chk("sra_ill", illegal, 0);
    drive(1, 2'b11, 3'b101, 7'b0000001, 7'b0010011, 5'd2);
    step();
    chk("ill_ctrl", alu_ctrl, 4'b0000);
    chk("ill_ill", illegal, 1);
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();
    chk("two_total", cnt_total, 2);
    chk("two_illegal", cnt_illegal, 1);

    // backpressure: two accepted, third waits
    reset_seq();
    out_ready = 1'b0;
    drive(1, 2'b00, 3'd0, 7'd0, 7'd0, 5'd1);
    step();
    drive(1, 2'b00, 3'd0, 7'd0, 7'd0, 5'd2);
    step();
    chk("bp_full_ready", in_ready, 0);
    drive(1, 2'b00, 3'd0, 7'd0, 7'd0, 5'd3);
    step();
    chk("bp_hold_tag1", out_tag, 1);
    out_ready = 1'b1;
    step();
    chk("bp_tag2", out_tag, 2);
    step();
    chk("bp_tag3", out_tag, 3);
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();

    // flush with both entries held and an input offered
    reset_seq();
    out_ready = 1'b0;
    drive(1, 2'b10, 3'b100, 7'd0, 7'b0110011, 5'd4);
    step();
    drive(1, 2'b10, 3'b110, 7'd0, 7'b0110011, 5'd5);
    step();
    flush = 1'b1;
    drive(1, 2'b10, 3'b111, 7'd0, 7'b0110011, 5'd9);
    step();
    flush = 1'b0;
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", cnt_total, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // counter saturation on the CNT_W=2 instance
    reset_seq();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b10, 3'b001, 7'b0000001, 7'b0110011, TAG_W'(i));
      step();
    end
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();
    chk("sat_total", s_cnt_total, 3);
    chk("sat_illegal", s_cnt_illegal, 3);
    chk("wide_total", cnt_total, 5);

    // reset mid-stream with two entries held
    reset_seq();
    out_ready = 1'b0;
    drive(1, 2'b01, 3'b000, 7'd0, 7'd0, 5'd11);
    step();
    drive(1, 2'b01, 3'b111, 7'd0, 7'd0, 5'd12);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_ctrl", alu_ctrl, 0);
    chk("mid_rst_tag", out_tag, 0);
    rst = 1'b1;
    drive(0, 2'd0, 3'd0, 7'd0, 7'd0, '0);
    step();
    chk("mid_rst_release", in_ready, 1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'd0;
        1: f7 = 7'd32;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            f7, 7'($urandom_range(0, 127)), TAG_W'($urandom_range(0, 31)));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 59) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
